// File: rtl/mod12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod12_pkg
//  Description : Shared types and constants for the modulo-12 sequencing
//                controller. The state type of the controller FSM, the
//                counter limits, and a preset range check used by both the
//                start-command check and the counter load path.
//  Optional    : MOD12_DOWN_EN (consumed by mod12_core and mod12_seq_ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
package mod12_pkg;

  // Sequencing states of the controller.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  // Counter range limits.
  localparam logic [3:0] MOD_MAX = 4'd11;
  localparam logic [3:0] MOD_MIN = 4'd0;

  // A preset is usable only if it is a legal counter value.
  function automatic logic preset_valid(input logic [3:0] value);
    return (value <= MOD_MAX);
  endfunction

endpackage : mod12_pkg
`default_nettype wire

// File: rtl/mod12_core.sv
`default_nettype none
// ============================================================================
//  Module      : mod12_core
//  Description : 4-bit modulo-12 counter datapath. Synchronous load has
//                priority over counting. A combinational wrap strobe flags
//                that the current enabled step crosses the 11/0 boundary.
//  Optional    : MOD12_DOWN_EN - adds i_dir; i_dir=1 counts down and the
//                0->11 step is reported as a wrap.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-low reset
//    i_en       in   advance the counter by one step
//    i_load     in   load i_load_val (wins over i_en)
//    i_load_val in   value to load, expected 0..11
//    i_dir      in   (MOD12_DOWN_EN only) 1 = count down
//    o_count    out  registered counter value
//    o_wrap     out  combinational: this enabled step wraps
// ============================================================================
module mod12_core
  import mod12_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
`ifdef MOD12_DOWN_EN
  input  logic       i_dir,
`endif
  output logic [3:0] o_count,
  output logic       o_wrap
);

  logic [3:0] r_count;
  logic       w_at_edge;
  logic [3:0] w_next;

`ifdef MOD12_DOWN_EN
  // The boundary value depends on direction: 11 going up, 0 going down.
  assign w_at_edge = i_dir ? (r_count == MOD_MIN) : (r_count == MOD_MAX);
  assign w_next    = i_dir ? (w_at_edge ? MOD_MAX : (r_count - 4'd1))
                           : (w_at_edge ? MOD_MIN : (r_count + 4'd1));
`else
  assign w_at_edge = (r_count == MOD_MAX);
  assign w_next    = w_at_edge ? MOD_MIN : (r_count + 4'd1);
`endif

  // Only an enabled step that does not also load can wrap.
  assign o_wrap = i_en && !i_load && w_at_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= MOD_MIN;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule : mod12_core
`default_nettype wire

// File: rtl/mod12_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod12_seq_ctrl
//  Description : Sequencing controller for a modulo-12 counter. Accepts
//                start/stop/pause, loads a preset, runs the counter for a
//                programmed number of wraps and pulses done on completion.
//                A target of 0 free-runs with the wrap count saturating.
//  Optional    : MOD12_DOWN_EN - adds input dir (1 = count down, 0->11 is
//                a wrap). Without it the block counts up only.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   rising-edge clock
//    rst          in   asynchronous active-low reset
//    start        in   begin a sequence (honoured in IDLE only)
//    stop         in   abort, highest priority
//    pause        in   level, freezes counting while high in RUN
//    preset       in   [3:0] start value for the counter
//    wraps_target in   [WRAP_W-1:0] wraps to run, 0 = free-run
//    dir          in   (MOD12_DOWN_EN only) count direction
//    count        out  [3:0] counter value 0..11
//    wraps        out  [WRAP_W-1:0] wraps completed since load
//    busy         out  high in LOAD/RUN/HOLD
//    done         out  one-cycle completion pulse
//    err          out  one-cycle pulse for start with preset > 11
// ============================================================================
module mod12_seq_ctrl
  import mod12_pkg::*;
#(
  parameter int WRAP_W = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [3:0]        preset,
  input  logic [WRAP_W-1:0] wraps_target,
`ifdef MOD12_DOWN_EN
  input  logic              dir,
`endif
  output logic [3:0]        count,
  output logic [WRAP_W-1:0] wraps,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [WRAP_W-1:0] r_wraps;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_load;
  logic              w_en;
  logic              w_wrap;
  logic [3:0]        w_load_val;
  logic [WRAP_W:0]   w_wraps_inc;
  logic              w_wraps_sat;
  logic              w_complete;

  // Counter control: stop beats everything, pause freezes RUN.
  assign w_load = (r_state == LOAD) && !stop;
  assign w_en   = (r_state == RUN) && !stop && !pause;

  // The preset was range-checked when start was accepted; if it changes to
  // an illegal value during LOAD, load the bottom of the range instead so
  // the counter can never leave 0..11.
  assign w_load_val = preset_valid(preset) ? preset : MOD_MIN;

  // One extra bit so a saturated count never aliases onto a small target.
  assign w_wraps_inc = {1'b0, r_wraps} + {{WRAP_W{1'b0}}, 1'b1};
  assign w_wraps_sat = &r_wraps;

  // Target is compared live, so it may be moved during RUN.
  assign w_complete = w_wrap && (wraps_target != '0) &&
                      (w_wraps_inc == {1'b0, wraps_target});

  mod12_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .i_load     (w_load),
    .i_load_val (w_load_val),
`ifdef MOD12_DOWN_EN
    .i_dir      (dir),
`endif
    .o_count    (count),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wraps <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // Stop in the same cycle as start suppresses the start.
          if (start && !stop) begin
            if (preset_valid(preset)) begin
              r_state <= LOAD;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wraps <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (pause) begin
            r_state <= HOLD;
          end else if (w_wrap) begin
            if (!w_wraps_sat) begin
              r_wraps <= w_wraps_inc[WRAP_W-1:0];
            end
            if (w_complete) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!pause) begin
            r_state <= RUN;
          end
        end
        DONE: begin
          // An abort arriving in DONE cancels the completion pulse.
          r_state <= IDLE;
          r_done  <= !stop;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wraps = r_wraps;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule : mod12_seq_ctrl
`default_nettype wire

// File: tb/tb_mod12_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod12_seq_ctrl
//  Description : Self-checking bench for mod12_seq_ctrl. A behavioural model
//                tracks the sequencing rules with plain integer arithmetic;
//                every falling edge compares all outputs with it. Directed
//                scenarios add literal expectations, followed by a random
//                command stream.
//  Optional    : MOD12_DOWN_EN - drives dir and adds a down-count scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod12_seq_ctrl;

  localparam int WRAP_W = 4;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_HOLD = 3;
  localparam int P_DONE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [3:0]        preset = 4'd0;
  logic [WRAP_W-1:0] wraps_target = '0;
  logic [3:0]        count;
  logic [WRAP_W-1:0] wraps;
  logic              busy;
  logic              done;
  logic              err;
`ifdef MOD12_DOWN_EN
  logic              dir = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mod12_seq_ctrl #(.WRAP_W(WRAP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .preset       (preset),
    .wraps_target (wraps_target),
`ifdef MOD12_DOWN_EN
    .dir          (dir),
`endif
    .count        (count),
    .wraps        (wraps),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_phase = P_IDLE;
  int m_count = 0;
  int m_wraps = 0;
  int m_done  = 0;
  int m_err   = 0;
  int m_busy;
  bit m_down;
  bit m_wrapped;

  assign m_busy = (m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_HOLD) ? 1 : 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE;
      m_count = 0;
      m_wraps = 0;
      m_done  = 0;
      m_err   = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
`ifdef MOD12_DOWN_EN
      m_down = dir;
`else
      m_down = 1'b0;
`endif
      if (stop) begin
        m_phase = P_IDLE;
      end else begin
        case (m_phase)
          P_IDLE: if (start) begin
            if (int'(preset) <= 11) m_phase = P_LOAD;
            else m_err = 1;
          end
          P_LOAD: begin
            m_count = int'(preset);
            m_wraps = 0;
            m_phase = P_RUN;
          end
          P_RUN: if (pause) begin
            m_phase = P_HOLD;
          end else begin
            m_wrapped = m_down ? (m_count == 0) : (m_count == 11);
            m_count   = m_down ? (m_count + 11) % 12 : (m_count + 1) % 12;
            if (m_wrapped) begin
              if (int'(wraps_target) != 0 && m_wraps + 1 == int'(wraps_target))
                m_phase = P_DONE;
              m_wraps = (m_wraps + 1 > WMAX) ? WMAX : m_wraps + 1;
            end
          end
          P_HOLD: if (!pause) m_phase = P_RUN;
          P_DONE: begin
            m_done  = 1;
            m_phase = P_IDLE;
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_wraps", 32'(wraps), 32'(m_wraps));
    chk("model_busy",  32'(busy),  32'(m_busy));
    chk("model_done",  32'(done),  32'(m_done));
    chk("model_err",   32'(err),   32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int n;
  bit prev_start;

  initial begin
    // Reset state
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wraps", 32'(wraps), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    #2 rst = 1'b1;

    // preset=10, one wrap
    step();
    preset = 4'd10; wraps_target = 1; start = 1'b1;
    step(); start = 1'b0;
    chk("t1_load_busy", 32'(busy), 32'd1);
    step(); chk("t1_e2_count", 32'(count), 32'd10);
    step(); chk("t1_e3_count", 32'(count), 32'd11);
    step(); chk("t1_e4_count", 32'(count), 32'd0);
    chk("t1_e4_wraps", 32'(wraps), 32'd1);
    chk("t1_e4_busy",  32'(busy),  32'd0);
    chk("t1_e4_done",  32'(done),  32'd0);
    step(); chk("t1_e5_done", 32'(done), 32'd1);
    chk("t1_e5_busy", 32'(busy), 32'd0);
    step(); chk("t1_e6_done", 32'(done), 32'd0);

    // preset=3, two wraps, pause while count=5
    preset = 4'd3; wraps_target = 2; start = 1'b1;
    step(); start = 1'b0;
    step(); chk("t2_e2_count", 32'(count), 32'd3);
    step(); step(); chk("t2_e4_count", 32'(count), 32'd5);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("t2_hold_count", 32'(count), 32'd5);
    end
    pause = 1'b0;
    step(); chk("t2_exit_count", 32'(count), 32'd5);
    chk("t2_exit_busy", 32'(busy), 32'd1);
    step(); chk("t2_resume_count", 32'(count), 32'd6);
    wait_done(100, n);
    chk("t2_done_latency", 32'(n), 32'd19);
    chk("t2_final_wraps", 32'(wraps), 32'd2);

    // illegal preset, then legal run from 0
    step();
    preset = 4'd12; wraps_target = 1; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_err",   32'(err),   32'd1);
    chk("t3_busy",  32'(busy),  32'd0);
    chk("t3_count", 32'(count), 32'd0);
    step(); chk("t3_err_off", 32'(err), 32'd0);
    preset = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    wait_done(100, n);
    chk("t3_done_latency", 32'(n), 32'd14);

    // free-run until saturation, then stop
    preset = 4'd5; wraps_target = 0; start = 1'b1;
    step(); start = 1'b0;
    repeat (12 * (WMAX + 2)) step();
    chk("t4_wraps_sat", 32'(wraps), 32'(WMAX));
    chk("t4_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    step(); step();

    // async reset mid-run at count=7
    preset = 4'd0; wraps_target = 0; start = 1'b1;
    step(); start = 1'b0;
    step();
    repeat (7) step();
    chk("t5_pre_count", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_wraps", 32'(wraps), 32'd0);
    chk("t5_async_busy",  32'(busy),  32'd0);
    step(); step();
    #2 rst = 1'b1;
    step(); step();
    chk("t5_idle_busy",  32'(busy),  32'd0);
    chk("t5_idle_count", 32'(count), 32'd0);

`ifdef MOD12_DOWN_EN
    // down count: 1,0,11 with a wrap on 0->11
    dir = 1'b1; preset = 4'd1; wraps_target = 1; start = 1'b1;
    step(); start = 1'b0;
    step(); chk("t6_count1", 32'(count), 32'd1);
    step(); chk("t6_count0", 32'(count), 32'd0);
    step(); chk("t6_count11", 32'(count), 32'd11);
    chk("t6_wraps", 32'(wraps), 32'd1);
    step(); chk("t6_done", 32'(done), 32'd1);
    dir = 1'b0;
`endif

    // random command stream
    prev_start = 1'b0;
    wraps_target = 2;
    for (int i = 0; i < 1500; i++) begin
      stop  = ($urandom_range(31) == 0);
      if ($urandom_range(5) == 0) pause = ~pause;
      start = ($urandom_range(3) == 0);
      // keep the preset steady through the LOAD cycle that follows a start
      if (!prev_start) preset = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) wraps_target = WRAP_W'($urandom_range(3));
`ifdef MOD12_DOWN_EN
      dir = 1'($urandom_range(1));
`endif
      prev_start = start;
      step();
    end
    stop = 1'b0; start = 1'b0; pause = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mod12_seq_ctrl
`default_nettype wire
